// File: rtl/rr_stream_arbiter.sv
// Round-robin merge of NUM_REQ valid/ready streams into one registered output stage.
// Define RR_ARB_PACKET_LOCK_EN to hold the grant on one requester until its last beat.
module rr_stream_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    localparam int unsigned SRC_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    logic                  w_load_en;
    logic                  w_any;
    logic [SRC_W-1:0]      w_gnt_idx;
    logic [SRC_W-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0]    w_cand;
    logic [DATA_WIDTH-1:0] w_gnt_data;
    logic                  w_gnt_last;

    logic [SRC_W-1:0]      r_ptr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [SRC_W-1:0]      r_src;
    logic                  r_last;
    logic                  r_valid;

`ifdef RR_ARB_PACKET_LOCK_EN
    logic                  r_locked;
    logic [SRC_W-1:0]      r_lock_idx;

    // While a packet is open only its owner may compete.
    always_comb begin
        w_cand = req_valid;
        if (r_locked) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                w_cand[i] = req_valid[i] && (SRC_W'(i) == r_lock_idx);
            end
        end
    end
`else
    assign w_cand = req_valid;
`endif

    assign w_load_en = ~r_valid | out_ready;

    // First candidate at or after the pointer, scanning modulo NUM_REQ.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_any && w_cand[(32'(r_ptr) + k) % NUM_REQ]) begin
                w_any     = 1'b1;
                w_gnt_idx = SRC_W'((32'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        w_gnt_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == w_gnt_idx) begin
                w_gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_gnt_last = req_last[i];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + SRC_W'(1);

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_load_en && w_any && !reset && (SRC_W'(i) == w_gnt_idx);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_data     <= '0;
            r_src      <= '0;
            r_last     <= 1'b0;
            r_valid    <= 1'b0;
`ifdef RR_ARB_PACKET_LOCK_EN
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
`endif
        end else if (w_load_en) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_gnt_data;
                r_src   <= w_gnt_idx;
                r_last  <= w_gnt_last;
`ifdef RR_ARB_PACKET_LOCK_EN
                // Pointer moves past the owner only when its packet closes.
                if (w_gnt_last) begin
                    r_locked <= 1'b0;
                    r_ptr    <= w_ptr_next;
                end else begin
                    r_locked   <= 1'b1;
                    r_lock_idx <= w_gnt_idx;
                end
`else
                r_ptr   <= w_ptr_next;
`endif
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_last  = r_last;
    assign out_valid = r_valid;

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that shares one registered valid/ready pipeline stage between NUM_REQ requester streams. Each cycle the stage can accept a beat, the arbiter grants exactly one valid requester and captures its data, source index and last flag into the output register. The block sits between several producer pipelines and a single downstream consumer. It provides fair, one-cycle-latency, full-throughput merging with optional packet locking.

## Interface
- NUM_REQ, default 4: number of requester streams, 2..16.
- DATA_WIDTH, default 8: width of each beat.
- SRC_W, derived as $clog2(NUM_REQ): width of out_src. Not overridable.

- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i's beat is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  input  NUM_REQ  requester i holds a beat.
- req_last  input  NUM_REQ  beat is final beat of a packet. Only has an effect with the lock feature.
- req_ready  output  NUM_REQ  one-hot or zero; beat i transfers when req_valid[i] && req_ready[i].
- out_data  output  DATA_WIDTH  registered beat.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_last  output  1  registered req_last of that beat.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.

## Operation
- load_en = ~out_valid | out_ready. The stage accepts a new beat only when load_en is 1.
- Round-robin pointer ptr (SRC_W bits) has reset value 0.
- Grant selection:
  - The winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, … modulo NUM_REQ.
  - gnt_idx is the winner's index.
  - req_ready[i] = load_en && (i == gnt_idx) && any req_valid.
  - req_ready never depends on req_valid of any other index except through winner selection.
- Accepted beat (load_en && any valid):
  - out_data, out_src and out_last load the winner's values.
  - out_valid is set to 1.
  - ptr is set to (gnt_idx+1) mod NUM_REQ. When NUM_REQ is not a power of two, wrap explicitly from NUM_REQ-1 to 0.
- load_en with no valid requester: out_valid is cleared to 0. Data, src and last hold their values. ptr holds.
- When load_en is 0: no req_ready is asserted and all state holds. A requester's data may change only after its own transfer.
- Reset values:
  - out_valid = 0, out_data = 0, out_src = 0, out_last = 0, ptr = 0.
  - Lock state is cleared.
  - req_ready = 0 while reset is high.
- Reset asserted mid-operation discards the held beat immediately, asynchronously. There is no partial-packet recovery.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat/cycle when out_ready is held 1.
- Simultaneous events: when out_valid && out_ready, the old beat leaves and a new beat is accepted on the same edge.
- Combinational paths:
  - out_ready to req_ready.
  - req_valid to req_ready.
  - No combinational path from any input to out_*.
- Fairness: with all NUM_REQ requesters continuously valid, every requester is granted exactly once per NUM_REQ accepted beats.

## Configuration
- Macro RR_ARB_PACKET_LOCK_EN.
- Defined:
  - An accepted beat with last=0 sets locked=1 and lock_idx=gnt_idx.
  - While locked, only lock_idx can be granted. Other requesters wait even if lock_idx has req_valid=0.
  - An accepted beat with last=1 clears locked. ptr advances to lock_idx+1 only on that beat, and holds on non-last beats.
  - A single-beat packet (last=1 on its first beat) never locks.
- Undefined:
  - req_last is ignored for arbitration and only passes through to out_last.
  - ptr advances on every accepted beat.
  - No lock state exists in the design.

## Test plan
- Reset with all four req_valid=1 and out_ready=1 -> out_valid=0 and req_ready=0 during reset. After release, out_src is 0,1,2,3,0 on consecutive cycles with matching data.
- Only requester 2 valid, data 0xA5, out_ready=1 -> req_ready=4'b0100 the same cycle. out_data=0xA5 and out_src=2 one cycle later. Next cycle out_valid=0 if no further requests.
- out_ready=0 for 3 cycles with a beat held -> req_ready=0, and out_data/out_src stable. Releasing out_ready gives back-to-back transfer with no bubble.
- Requesters 1 and 3 valid, ptr=2 -> 3 granted first, then 1.
- Assert reset while out_valid=1 and out_ready=0 -> out_valid=0 immediately and ptr=0.
- With RR_ARB_PACKET_LOCK_EN: requester 0 sends 3 beats (last on the 3rd) while requester 1 stays valid -> out_src=0,0,0 then 1. Requester 0 idles one cycle mid-packet -> out_valid=0 that cycle and requester 1 is not granted.
